// File: rtl/branch_resolver_if.sv
// branch_resolver_if: execute-stage branch bus; master drives the instruction, slave resolves it.
interface branch_resolver_if;
  logic        freeze;
  logic        valid_in;
  logic        B;
  logic        S;
  logic [3:0]  cond;
  logic [3:0]  status_in;
  logic [31:0] pc_in;
  logic [23:0] imm24;
  logic        Branch_taken;
  logic [31:0] BranchAddr;
  logic        squash;
  logic [3:0]  status_out;
  modport master (
    output freeze, valid_in, B, S, cond, status_in, pc_in, imm24,
    input  Branch_taken, BranchAddr, squash, status_out
  );
  modport slave (
    input  freeze, valid_in, B, S, cond, status_in, pc_in, imm24,
    output Branch_taken, BranchAddr, squash, status_out
  );
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: ARM condition check, branch target, NZCV register and two-cycle wrong-path squash.
// Defining BRANCH_STATS_EN adds saturating br_count/taken_count outputs.
module branch_resolver (
  input logic clk,
  input logic rst,
  branch_resolver_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] br_count,
  output logic [15:0] taken_count
`endif
);
  typedef enum logic [1:0] {IDLE, SH1, SH2} state_t;
  state_t state, state_nxt;
  logic n, z, c, v, cond_ok, live;
  assign {n, z, c, v} = bus.status_out;
  always_comb begin
    cond_ok = 1'b0;
    case (bus.cond)
      4'h0: cond_ok = z;
      4'h1: cond_ok = ~z;
      4'h2: cond_ok = c;
      4'h3: cond_ok = ~c;
      4'h4: cond_ok = n;
      4'h5: cond_ok = ~n;
      4'h6: cond_ok = v;
      4'h7: cond_ok = ~v;
      4'h8: cond_ok = c & ~z;
      4'h9: cond_ok = ~c | z;
      4'hA: cond_ok = n == v;
      4'hB: cond_ok = n != v;
      4'hC: cond_ok = ~z & (n == v);
      4'hD: cond_ok = z | (n != v);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  assign live = bus.valid_in & ~bus.squash;
  assign bus.Branch_taken = live & bus.B & cond_ok;
  assign bus.BranchAddr = bus.pc_in + {{6{bus.imm24[23]}}, bus.imm24, 2'b00};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // a taken branch wins over freeze so the shadow lines up with the PC redirect
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = bus.Branch_taken ? SH1 : IDLE;
      SH1: state_nxt = bus.freeze ? SH1 : SH2;
      SH2: state_nxt = bus.freeze ? SH2 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb bus.squash = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.status_out <= 4'b0000;
    else if (live & bus.S & cond_ok) bus.status_out <= bus.status_in;
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      br_count <= 16'd0;
      taken_count <= 16'd0;
    end else begin
      if (live & bus.B & ~&br_count) br_count <= br_count + 16'd1;
      if (bus.Branch_taken & ~&taken_count) taken_count <= taken_count + 16'd1;
    end
`endif
endmodule
